// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1:2 demultiplexer.
package demux_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 4;

    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// Single-entry destination slot: holding register, valid state, accepted-word counter.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             can_accept
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // A write always wins: it fills an empty slot or refills a draining one.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (wr_en) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (!wr_en && rd_ready) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (wr_en) begin
            data_d  = wr_data;
            count_d = count_q + CNT_W'(1);
        end
    end

    assign valid      = (state_q == SLOT_FULL);
    assign data       = data_q;
    assign count      = count_q;
    assign can_accept = (state_q == SLOT_EMPTY) || rd_ready;

endmodule

// File: rtl/demux_8bit_reg.sv
// Registered 1:2 demultiplexer steering one producer stream into two handshaked slots.
module demux_8bit_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [CNT_W-1:0] out1_count,
    output logic [CNT_W-1:0] out2_count
);

    logic can1, can2;
    logic wr1, wr2;
    logic in_fire;

    // Ready follows only the selected slot; independent of in_valid.
    assign in_ready = (in_sel == SEL_OUT2) ? can2 : can1;
    assign in_fire  = in_valid && in_ready;
    assign wr1      = in_fire && (in_sel == SEL_OUT1);
    assign wr2      = in_fire && (in_sel == SEL_OUT2);

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr1),
        .wr_data    (in_data),
        .rd_ready   (out1_ready),
        .valid      (out1_valid),
        .data       (out1_data),
        .count      (out1_count),
        .can_accept (can1)
    );

    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot2 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr2),
        .wr_data    (in_data),
        .rd_ready   (out2_ready),
        .valid      (out2_valid),
        .data       (out2_data),
        .count      (out2_count),
        .can_accept (can2)
    );

endmodule

// File: tb/tb_demux_8bit_reg.sv
// Scoreboard bench for demux_8bit_reg: reference slot model plus per-slot expected-word queues.
module tb_demux_8bit_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out1_data, out2_data;
    logic       out1_valid, out2_valid;
    logic       out1_ready, out2_ready;
    logic [3:0] out1_count, out2_count;

    int n_cmp = 0;
    int n_err = 0;

    logic       m_v1, m_v2;
    logic [7:0] m_d1, m_d2;
    logic [3:0] m_c1, m_c2;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    demux_8bit_reg dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out1_count (out1_count),
        .out2_count (out2_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_v1 = 1'b0; m_v2 = 1'b0;
        m_d1 = 8'h00; m_d2 = 8'h00;
        m_c1 = 4'd0; m_c2 = 4'd0;
        q1.delete();
        q2.delete();
    endtask

    // Reset with a transfer offered; the offered word must be discarded.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hFF;
        out1_ready = 1'b0; out2_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        model_clear();
    endtask

    // One clock: drive, compare against the model before the edge, then advance the model.
    task automatic cycle(input logic v, input logic s, input logic [7:0] d,
                         input logic r1, input logic r2);
        logic exp_rdy, wr1, wr2, dr1, dr2;
        logic [7:0] w;
        in_valid = v; in_sel = s; in_data = d;
        out1_ready = r1; out2_ready = r2;
        @(negedge clk);
        exp_rdy = s ? (!m_v2 || r2) : (!m_v1 || r1);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("out1_valid", 32'(out1_valid), 32'(m_v1));
        check_eq("out2_valid", 32'(out2_valid), 32'(m_v2));
        check_eq("out1_data", 32'(out1_data), 32'(m_d1));
        check_eq("out2_data", 32'(out2_data), 32'(m_d2));
        check_eq("out1_count", 32'(out1_count), 32'(m_c1));
        check_eq("out2_count", 32'(out2_count), 32'(m_c2));
        dr1 = m_v1 && r1;
        dr2 = m_v2 && r2;
        wr1 = v && exp_rdy && !s;
        wr2 = v && exp_rdy && s;
        if (dr1) begin
            if (q1.size() == 0) check_eq("q1_underflow", 32'd1, 32'd0);
            else begin w = q1.pop_front(); check_eq("deliver1", 32'(out1_data), 32'(w)); end
        end
        if (dr2) begin
            if (q2.size() == 0) check_eq("q2_underflow", 32'd1, 32'd0);
            else begin w = q2.pop_front(); check_eq("deliver2", 32'(out2_data), 32'(w)); end
        end
        @(posedge clk);
        #1;
        if (wr1) begin q1.push_back(d); m_d1 = d; m_c1 = m_c1 + 4'd1; end
        if (wr2) begin q2.push_back(d); m_d2 = d; m_c2 = m_c2 + 4'd1; end
        m_v1 = (m_v1 && !dr1) || wr1;
        m_v2 = (m_v2 && !dr2) || wr2;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00;
        out1_ready = 1'b0; out2_ready = 1'b0;
        model_clear();
        @(posedge clk);
        do_reset();

        // Reset state and idle ready for both selects
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Basic steer into slot 1
        cycle(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        check_eq("steer_data1", 32'(out1_data), 32'h0A5);
        check_eq("steer_cnt1", 32'(out1_count), 32'd1);
        check_eq("steer_valid2", 32'(out2_valid), 32'd0);

        // Backpressure on slot 1, other slot still accepts
        cycle(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        check_eq("bp_hold1", 32'(out1_data), 32'h0A5);
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        check_eq("bp_other2", 32'(out2_data), 32'h03C);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Pass-through refill on slot 2
        cycle(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
        check_eq("refill_valid2", 32'(out2_valid), 32'd1);
        check_eq("refill_data2", 32'(out2_data), 32'h022);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

        // Counter wrap on slot 2 after a clean reset
        do_reset();
        cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 8'(i + 8'h40), 1'b0, 1'b1);
        end
        check_eq("wrap_cnt2", 32'(out2_count), 32'd0);
        check_eq("wrap_cnt1", 32'(out1_count), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-operation with both slots full
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        check_eq("pre_rst_v1", 32'(out1_valid), 32'd1);
        check_eq("pre_rst_v2", 32'(out2_valid), 32'd1);
        do_reset();
        check_eq("rst_v1", 32'(out1_valid), 32'd0);
        check_eq("rst_v2", 32'(out2_valid), 32'd0);
        check_eq("rst_d1", 32'(out1_data), 32'd0);
        check_eq("rst_d2", 32'(out2_data), 32'd0);
        check_eq("rst_c1", 32'(out1_count), 32'd0);
        check_eq("rst_c2", 32'(out2_count), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
